lifo_stack: RTL

Synchronous last-in/first-out buffer of signed data words with registered pop output, occupancy count, full/empty flags and one-cycle overflow/underflow error pulses. It is the stack companion to the team's FIFO and is the DUT driven by the shared directed-check tasks: the 1-bit flags, the 6-bit count and the 8-bit signed data are all checked at negedge of the clock. It sits between a producer that pushes words and a consumer that pops the most recent word.

---
 rtl/lifo_pkg.sv | 17 +
 rtl/lifo_stack_if.sv | 29 ++
 rtl/lifo_ram.sv | 32 +++
 rtl/lifo_stack.sv | 118 +++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared parameters and types for the LIFO stack.
//   DATA_W : data word width (two's-complement signed)
//   DEPTH  : number of stack entries (power of two, >= 2)
//   CNT_W  : occupancy count width, holds 0..DEPTH inclusive
//   ADDR_W : storage address width
package lifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic        [CNT_W-1:0]  cnt_t;
  typedef logic        [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/lifo_stack_if.sv
// Push/pop bus of the LIFO stack.
//   master : producer/consumer side, drives push, push_data, pop
//   slave  : stack side, drives pop_data, pop_valid, full, empty, count,
//            overflow, underflow
interface lifo_stack_if;
  import lifo_pkg::*;

  logic  push;
  data_t push_data;
  logic  pop;
  data_t pop_data;
  logic  pop_valid;
  logic  full;
  logic  empty;
  cnt_t  count;
  logic  overflow;
  logic  underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/lifo_ram.sv
// Stack storage: Depth x DataW array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module lifo_ram #(
  parameter int unsigned Depth = 32,
  parameter int unsigned DataW = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO of signed words with registered pop output, occupancy
// count, registered full/empty flags and one-cycle overflow/underflow pulses.
//   clk : clock, all state changes on posedge
//   rst : synchronous active-high reset (pointer and outputs only)
//   bus : lifo_stack_if slave modport
//         push/push_data/pop in; pop_data/pop_valid/full/empty/count/
//         overflow/underflow out, all registered
module lifo_stack
  import lifo_pkg::*;
(
  input logic         clk,
  input logic         rst,
  lifo_stack_if.slave bus
);

  cnt_t  count_q, count_d;
  logic  full_q, full_d;
  logic  empty_q, empty_d;
  data_t pop_data_q, pop_data_d;
  logic  pop_valid_q, pop_valid_d;
  logic  overflow_q, overflow_d;
  logic  underflow_q, underflow_d;

  logic  ram_we;
  addr_t ram_waddr;
  data_t ram_rdata;
  addr_t top_addr;

  // Top of stack is entry count-1; the value at count==0 is never consumed.
  assign top_addr = addr_t'(count_q - cnt_t'(1));

  lifo_ram #(
    .Depth (DEPTH),
    .DataW (DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.push_data),
    .raddr_i (top_addr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = count_q[ADDR_W-1:0];

    // empty and full are never both set, so the patterns below are disjoint.
    unique casez ({bus.push, bus.pop, empty_q, full_q})
      4'b10?0: begin
        ram_we  = 1'b1;
        count_d = count_q + cnt_t'(1);
      end
      4'b10?1: begin
        overflow_d = 1'b1;
      end
      4'b010?: begin
        pop_data_d  = ram_rdata;
        pop_valid_d = 1'b1;
        count_d     = count_q - cnt_t'(1);
      end
      4'b011?: begin
        underflow_d = 1'b1;
      end
      // Swap: old top is read asynchronously before the edge overwrites it.
      4'b110?: begin
        pop_data_d  = ram_rdata;
        pop_valid_d = 1'b1;
        ram_we      = 1'b1;
        ram_waddr   = top_addr;
      end
      // Bypass on empty: the pushed word goes straight to the output.
      4'b111?: begin
        pop_data_d  = bus.push_data;
        pop_valid_d = 1'b1;
      end
      4'b00??: begin
      end
    endcase

    full_d  = (count_d == cnt_t'(DEPTH));
    empty_d = (count_d == cnt_t'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
